// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding word memory responder with fixed wait latency
// Requests are captured in IDLE, held in BUSY for WAIT_CYCLES, and answered from RESP.
module data_mem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [3:0]  ReqByteEn,
  output logic        ReqReady,
  output logic        RspValid,
  output logic [31:0] RspRData,
  output logic        RspErr,
  input  logic        RspReady
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  waitCnt;
  logic        capWrite;
  logic [31:0] capAddr;
  logic [31:0] capWData;
  logic [3:0]  capByteEn;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          doAccess;
  logic          accWrite;
  logic [31:0]   accAddr;
  logic [31:0]   accWData;
  logic [3:0]    accByteEn;
  logic          accErr;
  logic [AW-1:0] accIdx;
  logic [31:0]   rspData;

  assign ReqReady = (state == IDLE);
  assign RspValid = (state == RESP);
  assign accept   = ReqValid && (state == IDLE);

  // With no wait cycles the access happens on the accept edge itself, so the
  // live request is used; otherwise the captured copy drives the access.
  assign doAccess = ((state == BUSY) && (waitCnt == 4'd1)) ||
                    (accept && (WAIT_CYCLES == 0));

  always_comb begin
    accWrite  = capWrite;
    accAddr   = capAddr;
    accWData  = capWData;
    accByteEn = capByteEn;
    if (state == IDLE) begin
      accWrite  = ReqWrite;
      accAddr   = ReqAddr;
      accWData  = ReqWData;
      accByteEn = ReqByteEn;
    end
  end

  assign accErr  = (accAddr[1:0] != 2'b00) || (accAddr[31:2] >= 30'(DEPTH));
  assign accIdx  = accAddr[AW+1:2];
  assign rspData = (accErr || accWrite) ? 32'h0 : mem[accIdx];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      capWrite  <= 1'b0;
      capAddr   <= 32'h0;
      capWData  <= 32'h0;
      capByteEn <= 4'h0;
      RspRData  <= 32'h0;
      RspErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            capWrite  <= ReqWrite;
            capAddr   <= ReqAddr;
            capWData  <= ReqWData;
            capByteEn <= ReqByteEn;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state   <= BUSY;
              waitCnt <= 4'(WAIT_CYCLES);
            end
          end
        end
        BUSY: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (RspReady) begin
            state    <= IDLE;
            RspRData <= 32'h0;
            RspErr   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (doAccess) begin
        RspRData <= rspData;
        RspErr   <= accErr;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (doAccess && accWrite && !accErr) begin
      for (int b = 0; b < 4; b++) begin
        if (accByteEn[b]) begin
          mem[accIdx][8*b +: 8] <= accWData[8*b +: 8];
        end
      end
    end
  end

endmodule
